// File: rtl/prog_down_timer_pkg.sv
// Shared types and constants for the programmable down-counting interval timer.
// Imported by the nibble counter and the timer top level.
package timer_pkg;

    localparam int NIBBLE_W = 4;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

endpackage

// File: rtl/prog_down_timer_nibble.sv
// One 4-bit synchronous down-counter stage with TTL-style load/enable/terminal count.
// Stages cascade by feeding tc of stage k into cet of stage k+1.
module ls_down_nibble
    import timer_pkg::*;
(
    input  logic                cp,
    input  logic                rst_b,
    input  logic [NIBBLE_W-1:0] p,
    input  logic                load_b,
    input  logic                cet,
    input  logic                cep,
    output logic [NIBBLE_W-1:0] q,
    output logic                tc
);

    always_ff @(posedge cp or negedge rst_b) begin
        if (!rst_b) begin
            q <= '0;
        end else if (!load_b) begin
            q <= p;
        end else if (cep && cet) begin
            q <= q - 1'b1;
        end
    end

    assign tc = cet & (q == '0);

endmodule

// File: rtl/prog_down_timer.sv
// Programmable down-counting interval timer: cascaded nibble counters, reload
// register, IDLE/RUN/EXPIRED sequencing and a registered one-cycle expiry pulse.
//
//   state   | meaning
//   --------+-----------------------------------------------
//   IDLE    | after reset, nothing counting
//   RUN     | counting down, expiry at the zero crossing
//   EXPIRED | one-shot count finished, q held at zero
module prog_down_timer
    import timer_pkg::*;
#(
    parameter int NIBBLES = 4,
    localparam int W      = NIBBLE_W * NIBBLES
) (
    input  logic         cp,
    input  logic         rst_b,
    input  logic [W-1:0] reload,
    input  logic         load_b,
    input  logic         start,
    input  logic         en,
    input  logic         mode,
    output logic [W-1:0] q,
    output logic         tc,
    output logic         pulse,
    output logic         busy
);

    timer_state_t state, state_next;
    logic [W-1:0] reload_reg;
    logic [W-1:0] cnt_p;
    logic         cnt_load_b;
    logic         cnt_cep;
    logic         run;
    logic         zero;
    logic         pulse_next;
    logic [NIBBLES:0] borrow;

    assign run  = (state == RUN);
    assign zero = (q == '0);
    assign busy = run;

    // Borrow chain: the last stage's tc is the global run & en & (q==0) term.
    assign borrow[0] = run & en;
    assign tc        = borrow[NIBBLES];

    // cep is withheld at the global zero so a one-shot holds 0 instead of wrapping.
    assign cnt_cep = ~zero;

    // External load, start and a periodic zero crossing all use the parallel load path.
    assign cnt_load_b = ~(~load_b | start | (tc & (mode == MODE_PERIODIC)));
    assign cnt_p      = load_b ? reload_reg : reload;

    genvar k;
    generate
        for (k = 0; k < NIBBLES; k++) begin : g_nib
            ls_down_nibble u_nib (
                .cp     (cp),
                .rst_b  (rst_b),
                .p      (cnt_p[k*NIBBLE_W +: NIBBLE_W]),
                .load_b (cnt_load_b),
                .cet    (borrow[k]),
                .cep    (cnt_cep),
                .q      (q[k*NIBBLE_W +: NIBBLE_W]),
                .tc     (borrow[k+1])
            );
        end
    endgenerate

    always_ff @(posedge cp or negedge rst_b) begin
        if (!rst_b) begin
            reload_reg <= '0;
        end else if (!load_b) begin
            reload_reg <= reload;
        end
    end

    always_ff @(posedge cp or negedge rst_b) begin
        if (!rst_b) begin
            state <= IDLE;
            pulse <= 1'b0;
        end else begin
            state <= state_next;
            pulse <= pulse_next;
        end
    end

    always_comb begin
        state_next = state;
        pulse_next = 1'b0;
        if (!load_b) begin
            state_next = state;
        end else if (start) begin
            state_next = RUN;
        end else if (tc) begin
            pulse_next = 1'b1;
            if (mode == MODE_ONESHOT) begin
                state_next = EXPIRED;
            end
        end
    end

endmodule

// File: tb/tb_prog_down_timer.sv
// Directed bench for prog_down_timer: an integer-level reference model checked
// every cycle, plus literal expectations at key points of each scenario.
module tb_prog_down_timer;

    localparam int W = 16;

    logic         cp = 1'b0;
    logic         rst_b = 1'b1;
    logic [W-1:0] reload = '0;
    logic         load_b = 1'b1;
    logic         start = 1'b0;
    logic         en = 1'b0;
    logic         mode = 1'b0;
    logic [W-1:0] q;
    logic         tc;
    logic         pulse;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    // reference model: state 0 idle, 1 counting, 2 one-shot finished
    int m_q = 0, m_rr = 0, m_st = 0;
    bit m_pulse = 1'b0;

    prog_down_timer #(.NIBBLES(4)) dut (
        .cp     (cp),
        .rst_b  (rst_b),
        .reload (reload),
        .load_b (load_b),
        .start  (start),
        .en     (en),
        .mode   (mode),
        .q      (q),
        .tc     (tc),
        .pulse  (pulse),
        .busy   (busy)
    );

    always #5 cp = ~cp;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge cp or negedge rst_b) begin
        if (!rst_b) begin
            m_q = 0; m_rr = 0; m_st = 0; m_pulse = 1'b0;
        end else begin
            bit p;
            p = 1'b0;
            if (!load_b) begin
                m_rr = int'(reload);
                m_q  = int'(reload);
            end else if (start) begin
                m_q  = m_rr;
                m_st = 1;
            end else if (m_st == 1 && en) begin
                if (m_q != 0) begin
                    m_q = m_q - 1;
                end else begin
                    p = 1'b1;
                    if (mode) m_st = 2;
                    else      m_q = m_rr;
                end
            end
            m_pulse = p;
        end
    end

    always @(negedge cp) begin
        if (chk_on) begin
            chk("model_q",     32'(q),     32'(m_q));
            chk("model_tc",    32'(tc),    32'((m_st == 1) && en && (m_q == 0)));
            chk("model_pulse", 32'(pulse), 32'(m_pulse));
            chk("model_busy",  32'(busy),  32'(m_st == 1));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge cp);
            #1;
        end
    endtask

    task automatic run_count(input int n, output int c);
        c = 0;
        repeat (n) begin
            step(1);
            if (pulse === 1'b1) c++;
        end
    endtask

    task automatic do_load(input logic [W-1:0] v);
        reload = v; load_b = 1'b0;
        step(1);
        load_b = 1'b1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    initial begin
        int c;
        logic [4:0] en_pat;

        // asynchronous reset mid-clock, observed before any edge
        #3 rst_b = 1'b0;
        #1;
        chk("rst_q",     32'(q),     32'h0);
        chk("rst_pulse", 32'(pulse), 32'h0);
        chk("rst_busy",  32'(busy),  32'h0);
        @(posedge cp); #1;
        rst_b = 1'b1;
        chk_on = 1'b1;

        en = 1'b1;
        step(10);
        chk("idle_q",  32'(q),  32'h0);
        chk("idle_tc", 32'(tc), 32'h0);

        // periodic divide by 4
        mode = 1'b0;
        do_load(16'h0003);
        do_start();
        chk("per_q_start", 32'(q), 32'h3);
        chk("per_busy",    32'(busy), 32'h1);
        run_count(12, c);
        chk("per_pulses", 32'(c), 32'd3);
        chk("per_q_end",  32'(q), 32'h3);

        // one-shot from 2
        mode = 1'b1;
        do_load(16'h0002);
        do_start();
        chk("os_q_start", 32'(q), 32'h2);
        run_count(8, c);
        chk("os_pulses", 32'(c), 32'd1);
        chk("os_busy",   32'(busy), 32'h0);
        chk("os_q",      32'(q), 32'h0);
        do_start();
        chk("os_restart_q",    32'(q), 32'h2);
        chk("os_restart_busy", 32'(busy), 32'h1);
        run_count(4, c);
        chk("os_restart_pulses", 32'(c), 32'd1);

        // borrow across nibbles
        mode = 1'b0;
        do_load(16'h0100);
        do_start();
        step(1);
        chk("brw_q_ff", 32'(q), 32'h00FF);
        step(255);
        chk("brw_q_0",     32'(q), 32'h0000);
        chk("brw_pulse_0", 32'(pulse), 32'h0);
        step(1);
        chk("brw_pulse", 32'(pulse), 32'h1);
        chk("brw_reload", 32'(q), 32'h0100);

        // enable gating, reload 1
        do_load(16'h0001);
        do_start();
        c = 0;
        en_pat = 5'b11001;
        for (int r = 0; r < 2; r++) begin
            for (int i = 4; i >= 0; i--) begin
                en = en_pat[i];
                #1;
                if (!en) chk("gate_tc_low", 32'(tc), 32'h0);
                step(1);
                if (pulse === 1'b1) c++;
            end
        end
        chk("gate_pulses", 32'(c), 32'd3);
        en = 1'b1;

        // reset during RUN
        step(2);
        #2 rst_b = 1'b0;
        #1;
        chk("rrun_q",    32'(q),    32'h0);
        chk("rrun_busy", 32'(busy), 32'h0);
        @(posedge cp); #1;
        rst_b = 1'b1;
        run_count(3, c);
        chk("rrun_no_pulse", 32'(c), 32'd0);

        // simultaneous load and start in IDLE: load wins
        reload = 16'h0055; load_b = 1'b0; start = 1'b1;
        step(1);
        load_b = 1'b1; start = 1'b0;
        chk("ls_q",    32'(q),    32'h55);
        chk("ls_busy", 32'(busy), 32'h0);

        // reload 0 periodic: pulse every enabled cycle
        do_load(16'h0000);
        do_start();
        run_count(5, c);
        chk("r0_pulses", 32'(c), 32'd5);

        chk_on = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_down_timer.md
Name: prog_down_timer

Overview:
- Programmable down-counting interval timer built from cascaded 4-bit synchronous down-counter nibbles, with TTL-style load/enable/terminal-count semantics.
- Counts a loaded reload value down to zero, then emits a one-cycle expiry pulse.
- Periodic mode reloads automatically; one-shot mode stops at zero.
- Used as the frame/line/event divider alongside the existing up-counter parts, and cascades through its tc output.

Parameters:
- NIBBLES, 4, number of cascaded 4-bit stages; counter width W = 4*NIBBLES (16 by default).

Ports:
- cp  input  1  clock; every register updates on the rising edge.
- rst_b  input  1  asynchronous reset, active-low.
- reload  input  W  value captured by a load.
- load_b  input  1  synchronous load, active-low.
- start  input  1  one-cycle strobe that arms or restarts the count.
- en  input  1  count enable; when low, all counting state freezes.
- mode  input  1  0 = periodic auto-reload, 1 = one-shot.
- q  output  W  current count.
- tc  output  1  combinational terminal count for cascading.
- pulse  output  1  registered one-cycle expiry strobe.
- busy  output  1  high while the FSM is in RUN.

Behaviour:
- Reset (asynchronous, rst_b low): q=0, reload_reg=0, state=IDLE, pulse=0, busy=0. All outputs hold these values until the first cp edge after rst_b rises.
- States:
  - IDLE: after reset, nothing counting.
  - RUN: counting.
  - EXPIRED: one-shot finished.
- Priority each edge: load_b low > start > counting.
- Load (load_b=0): reload_reg<=reload and q<=reload. State is unchanged, so a load during RUN re-seeds the current count. No pulse is generated.
- Start (load_b=1, start=1), from any state: q<=reload_reg and state<=RUN. The start is honoured regardless of en.
- RUN with en=1, q!=0: q<=q-1.
- RUN with en=1, q==0:
  - pulse<=1 for exactly one cycle.
  - mode=0: q<=reload_reg, state stays RUN.
  - mode=1: state<=EXPIRED, q holds 0.
- Expiry period: reload_reg+1 enabled cycles between pulses. With reload_reg=0 in periodic mode, pulse is high on every enabled cycle.
- en=0: q, state and pulse generation freeze. pulse deasserts on the next edge. A held-off expiry fires only once en returns.
- mode is sampled at the zero-crossing edge only; changing it mid-count is legal.
- tc = (state==RUN) & en & (q==0), purely combinational. It is used as cet of a following stage.
- busy = (state==RUN), registered as state.
- IDLE/EXPIRED: q holds, except when a load occurs. tc=0 and no pulse is generated.
- Arithmetic: unsigned. Nibble k decrements only when en=1 and nibbles 0..k-1 are all zero (borrow chain via nibble tc/cet). A nibble wraps 0->F on borrow, except at the global zero, where reload/hold applies.
- Reset mid-count: immediate return to reset values; no pulse on release.
- Simultaneous load_b=0 and start=1: the load wins and start is ignored. Software issues start on a later cycle.

Decomposition:
- Shared package (timer_pkg):
  - state enum timer_state_t {IDLE, RUN, EXPIRED}
  - MODE_PERIODIC=1'b0, MODE_ONESHOT=1'b1
  - NIBBLE_W=4
- Sub-module ls_down_nibble:
  - Ports: q[3:0], tc, p[3:0], load_b, cet, cep, cp, rst_b.
  - Asynchronous clear, synchronous parallel load, and decrement when cep&cet.
  - tc = cet & (q==0).
  - Instantiated NIBBLES times in a generate loop, with the borrow chain wired through tc->cet.
  - The top level adds reload_reg, the FSM, global-zero reload muxing, and pulse/busy.

Test Plan:
- Reset/idle: assert rst_b=0 mid-clock -> q=0, pulse=0, busy=0 immediately, without waiting for an edge. Release, then clock 10 cycles with en=1 -> q stays 0 and tc=0.
- Periodic divide: load 0x0003, start, mode=0, en=1 -> q runs 3,2,1,0,3,2,...; pulse high on every 4th edge; busy=1 throughout.
- One-shot: load 0x0002, start, mode=1 -> q runs 2,1,0; one pulse; state EXPIRED with busy=0 and q=0. Further cycles give no pulse. A new start re-runs from 2.
- Nibble borrow: load 0x0100, start -> after 1 cycle q=0x00FF; after 256 cycles total q=0x0000; pulse on the following edge; reload to 0x0100.
- Enable gating: periodic with reload 0x0001, toggle en 1,0,0,1,1 -> q changes only on en=1 cycles; tc=0 whenever en=0; pulse count equals (enabled cycles)/2.
- Priority and corner cases:
  - load_b=0 together with start=1 in IDLE -> q=reload, state IDLE.
  - reload=0 in periodic mode -> pulse on every enabled cycle.
  - rst_b low during RUN -> q=0, busy=0; no pulse after release.
